// File: rtl/mole_driver.sv
// Whack-a-mole producer: spawns one LFSR-chosen mole per window, resolves each
// window as hit or miss from the latched buttons, and keeps score and misses.
module mole_driver #(
  parameter int         TICK_LO    = 16,
  parameter int         TICK_MED   = 8,
  parameter int         TICK_HI    = 4,
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  parameter int         MISS_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] counter,
  input  logic       start,
  input  logic [3:0] hit,
  output logic [3:0] mole,
  output logic [7:0] score,
  output logic [1:0] misses,
  output logic       window_done,
  output logic       game_over
);

  localparam int TICK_MAX = (TICK_LO > TICK_MED) ?
                            ((TICK_LO > TICK_HI) ? TICK_LO : TICK_HI) :
                            ((TICK_MED > TICK_HI) ? TICK_MED : TICK_HI);
  localparam int WCW = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
  localparam logic [1:0] MISS_LIM = 2'(MISS_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    WAIT,
    RESOLVE,
    OVER
  } state_t;

  state_t         state;
  logic [7:0]     lfsr;
  logic [3:0]     prev_mole;
  logic [WCW-1:0] wcnt;

  logic [7:0] lfsr_nx;
  logic [3:0] cand;
  logic [3:0] spawn_mole;
  logic       press_ok;
  logic       press_any;

  // x^8+x^6+x^5+x^4+1, shifting left with the feedback entering bit 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [WCW-1:0] window_load(input logic [3:0] lvl);
    if (lvl <= 4'd4)      return WCW'(TICK_LO - 1);
    else if (lvl <= 4'd9) return WCW'(TICK_MED - 1);
    else                  return WCW'(TICK_HI - 1);
  endfunction

  assign lfsr_nx    = lfsr_step(lfsr);
  assign cand       = 4'b0001 << lfsr_nx[1:0];
  // Never show the same hole twice in a row.
  assign spawn_mole = (cand == prev_mole) ? {cand[2:0], cand[3]} : cand;
  assign press_ok   = |(hit & mole);
  assign press_any  = |hit;

  // NOTE: every register here uses <= so all updates in a cycle see the
  // pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      prev_mole   <= 4'b0000;
      wcnt        <= '0;
      mole        <= 4'b0000;
      score       <= 8'd0;
      misses      <= 2'd0;
      window_done <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mole <= 4'b0000;
          if (start) begin
            score  <= 8'd0;
            misses <= 2'd0;
            state  <= SPAWN;
          end
        end

        SPAWN: begin
          lfsr      <= lfsr_nx;
          mole      <= spawn_mole;
          prev_mole <= spawn_mole;
          wcnt      <= window_load(counter);
          state     <= WAIT;
        end

        WAIT: begin
          // A correct bit wins over wrong bits and over the final-cycle timeout.
          if (press_ok) begin
            if (score != 8'hFF) score <= score + 8'd1;
            mole        <= 4'b0000;
            window_done <= 1'b1;
            state       <= RESOLVE;
          end else if (press_any || wcnt == '0) begin
            if (misses != MISS_LIM) misses <= misses + 2'd1;
            mole        <= 4'b0000;
            window_done <= 1'b1;
            state       <= RESOLVE;
          end else begin
            wcnt <= wcnt - WCW'(1);
          end
        end

        RESOLVE: begin
          window_done <= 1'b0;
          if (misses == MISS_LIM) begin
            game_over <= 1'b1;
            state     <= OVER;
          end else begin
            state <= SPAWN;
          end
        end

        OVER: begin
          mole <= 4'b0000;
          if (start) begin
            score     <= 8'd0;
            misses    <= 2'd0;
            game_over <= 1'b0;
            state     <= SPAWN;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
